// File: rtl/display_pkg.sv
// Shared constants and helpers for the four-digit BCD display scanner.
package display_pkg;

  localparam int         DIGITS  = 4;
  localparam logic [3:0] SEL_OFF = 4'b1111;

  function automatic logic [3:0] sel_onehot_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // A digit is blanked when it and every more significant nibble are zero.
  function automatic logic [3:0] lz_mask(input logic [15:0] bcd);
    logic [3:0] m;
    m[3] = (bcd[15:12] == 4'h0);
    m[2] = m[3] && (bcd[11:8] == 4'h0);
    m[1] = m[2] && (bcd[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot counter for the display scanner: counts 0..PRESCALE-1 and flags the wrap.
module scan_prescaler #(
  parameter  int PRESCALE = 1000,
  localparam int CW       = $clog2(PRESCALE)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic [CW-1:0] o_cnt,
  output logic          o_tick
);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(PRESCALE - 1));
  assign o_cnt  = r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed BCD scanner with shadow-register updates, leading-zero
// blanking and an anti-ghosting blank window at the start of every digit slot.
module display_scanner
  import display_pkg::*;
#(
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [15:0] i_d,
  input  logic        i_lzb,
  output logic [3:0]  o_a,
  output logic        o_en,
  output logic [3:0]  o_sel_n,
  output logic        o_frame
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);

  logic [CW-1:0] w_cnt;
  logic          w_tick;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_cnt   (w_cnt),
    .o_tick  (w_tick)
  );

  logic [IW-1:0] r_idx;
  logic [15:0]   r_disp;
  logic [15:0]   r_shd;
  logic          r_pend;
  logic [3:0]    r_a;
  logic          r_en;
  logic [3:0]    r_sel_n;
  logic          r_frame;

  logic          w_boundary;
  logic          w_blank;
  logic          w_lz;
  logic [IW-1:0] w_idx_nxt;
  logic [15:0]   w_disp_nxt;
  logic [3:0]    w_mask;
  logic [3:0]    w_a_nxt;
  logic [3:0]    w_sel_nxt;
  logic          w_en_nxt;

  // Outputs are computed from the next-state values so they track CNT/IDX
  // on the same edge; the blank test is "next CNT < BLANK_CYC" rewritten
  // in terms of the current count.
  always_comb begin
    w_boundary = w_tick && (r_idx == IW'(DIGITS - 1));
    w_idx_nxt  = w_tick ? r_idx + IW'(1) : r_idx;
    w_disp_nxt = (w_boundary && r_pend) ? r_shd : r_disp;
    w_blank    = w_tick || (w_cnt < CW'(BLANK_CYC - 1));
    w_mask     = lz_mask(w_disp_nxt);
    w_lz       = i_lzb && w_mask[w_idx_nxt];
    w_a_nxt    = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_sel_nxt  = SEL_OFF;
    w_en_nxt   = 1'b0;
    if (!w_blank && !w_lz) begin
      w_sel_nxt = sel_onehot_n(w_idx_nxt);
      w_en_nxt  = 1'b1;
    end
  end

  // A boundary copies the pre-LOAD shadow; a coincident LOAD leaves PEND set.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx   <= '0;
      r_disp  <= '0;
      r_shd   <= '0;
      r_pend  <= 1'b0;
      r_a     <= 4'h0;
      r_en    <= 1'b0;
      r_sel_n <= SEL_OFF;
      r_frame <= 1'b0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_disp  <= w_disp_nxt;
      r_shd   <= i_load ? i_d : r_shd;
      r_pend  <= i_load || (r_pend && !w_boundary);
      r_a     <= w_a_nxt;
      r_en    <= w_en_nxt;
      r_sel_n <= w_sel_nxt;
      r_frame <= w_boundary;
    end
  end

  assign o_a     = r_a;
  assign o_en    = r_en;
  assign o_sel_n = r_sel_n;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with PRESCALE=8, BLANK_CYC=2.
module tb_display_scanner;

  localparam int PS = 8;
  localparam int BC = 2;
  localparam int FR = 4 * PS;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic        lzb   = 1'b0;
  logic [15:0] d     = 16'h0;
  logic [3:0]  a;
  logic        en;
  logic [3:0]  sel_n;
  logic        frame;

  display_scanner #(.PRESCALE(PS), .BLANK_CYC(BC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_load  (load),
    .i_d     (d),
    .i_lzb   (lzb),
    .o_a     (a),
    .o_en    (en),
    .o_sel_n (sel_n),
    .o_frame (frame)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int k      = 0;   // edges since reset released

  typedef struct {
    logic [15:0] d;
    logic        lzb;
    logic [3:0]  lit;
    string       name;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [15:0] dv, input logic z,
                              input logic [3:0] l, input string n);
    vec_t v;
    v.d = dv; v.lzb = z; v.lit = l; v.name = n;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%h want=%h", nm, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic goto(input int p);
    int n;
    n = 0;
    while ((k % FR) != p && n < 2 * FR) begin
      step();
      n++;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    d    = v;
    step();
    load = 1'b0;
  endtask

  task automatic check_cycle(input vec_t v);
    int p, c, ix;
    logic [3:0] nib, es;
    p   = k % FR;
    c   = p % PS;
    ix  = p / PS;
    nib = v.d[ix*4 +: 4];
    es  = 4'b1111;
    es[ix] = 1'b0;
    chk({v.name, " frame"}, {15'h0, frame}, {15'h0, (p == 0)});
    if (c < BC) begin
      chk({v.name, " win_sel"}, {12'h0, sel_n}, 16'h000f);
      chk({v.name, " win_en"}, {15'h0, en}, 16'h0);
      if (v.lit[ix]) chk({v.name, " win_a"}, {12'h0, a}, {12'h0, nib});
    end else if (v.lit[ix]) begin
      chk({v.name, " sel"}, {12'h0, sel_n}, {12'h0, es});
      chk({v.name, " en"}, {15'h0, en}, 16'h1);
      chk({v.name, " a"}, {12'h0, a}, {12'h0, nib});
    end else begin
      chk({v.name, " lz_sel"}, {12'h0, sel_n}, 16'h000f);
      chk({v.name, " lz_en"}, {15'h0, en}, 16'h0);
    end
  endtask

  task automatic check_frame(input vec_t v);
    int n;
    n = 0;
    while ((k % FR) != 0 && n < 2 * FR) begin
      step();
      n++;
    end
    for (int j = 0; j < FR; j++) begin
      check_cycle(v);
      step();
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, " sel"}, {12'h0, sel_n}, 16'h000f);
    chk({nm, " en"}, {15'h0, en}, 16'h0);
    chk({nm, " a"}, {12'h0, a}, 16'h0);
    chk({nm, " frame"}, {15'h0, frame}, 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog k=%0d", k);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(16'h1234, 1'b0, 4'b1111, "scan1234");
    vecs[1] = mk(16'h0050, 1'b1, 4'b0011, "lzb0050");
    vecs[2] = mk(16'h0000, 1'b1, 4'b0001, "lzb0000");
    vecs[3] = mk(16'h0050, 1'b0, 4'b1111, "nolzb0050");
    vecs[4] = mk(16'h00A0, 1'b1, 4'b0011, "hexA0");
    vecs[5] = mk(16'h1000, 1'b1, 4'b1111, "lzb1000");
    vecs[6] = mk(16'h0300, 1'b1, 4'b0111, "lzb0300");

    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset("reset");
    end
    rst_n = 1'b1;
    k = 0;
    step();
    chk("post_rst_win sel", {12'h0, sel_n}, 16'h000f);
    step();
    chk("post_rst_d0 sel", {12'h0, sel_n}, 16'h000e);
    chk("post_rst_d0 en", {15'h0, en}, 16'h1);
    chk("post_rst_d0 a", {12'h0, a}, 16'h0);
    check_frame(mk(16'h0000, 1'b0, 4'b1111, "first_frame"));

    foreach (vecs[i]) begin
      goto(PS);
      lzb = vecs[i].lzb;
      do_load(vecs[i].d);
      check_frame(vecs[i]);
    end

    // Two loads in one frame: only the last one may ever be shown.
    goto(PS);
    lzb = 1'b0;
    do_load(16'h1111);
    goto(2 * PS);
    do_load(16'h9999);
    check_frame(mk(16'h9999, 1'b0, 4'b1111, "tearfree1"));
    check_frame(mk(16'h9999, 1'b0, 4'b1111, "tearfree2"));

    // LOAD coincident with the frame-boundary tick.
    goto(PS);
    do_load(16'h2222);
    goto(FR - 1);
    do_load(16'h7777);
    check_frame(mk(16'h2222, 1'b0, 4'b1111, "bnd_old"));
    check_frame(mk(16'h7777, 1'b0, 4'b1111, "bnd_new"));

    // Reset at IDX=2, CNT=5 wipes the display.
    lzb = 1'b1;
    goto(2 * PS + 5);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset("midrst");
    rst_n = 1'b1;
    k = 0;
    step();
    step();
    chk("midrst_d0 sel", {12'h0, sel_n}, 16'h000e);
    chk("midrst_d0 en", {15'h0, en}, 16'h1);
    chk("midrst_d0 a", {12'h0, a}, 16'h0);
    goto(PS + 2);
    chk("midrst_d1 sel", {12'h0, sel_n}, 16'h000f);
    chk("midrst_d1 en", {15'h0, en}, 16'h0);
    check_frame(mk(16'h0000, 1'b1, 4'b0001, "midrst_frame"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Four-digit time-multiplexed BCD display scanner, directly upstream of the seven-segment LED decoder. Holds a 16-bit packed-BCD value, steps through the digits at a prescaled rate, and drives the decoder's BCD inputs and enable together with an active-low digit-select bus. Provides tear-free updates via a shadow register, leading-zero blanking, and an anti-ghosting blank window at every digit change.

## Interface
- PRESCALE, 1000: clock cycles per digit slot; legal range 4..65535.
- BLANK_CYC, 2: cycles at the start of each slot with all digits off; legal range 1..PRESCALE-2.
- CLK  in  1  single system clock, rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- LOAD  in  1  one-cycle strobe; capture D into the shadow register.
- D  in  16  packed BCD: D[3:0] is digit 0 (least significant), D[15:12] is digit 3.
- LZB  in  1  leading-zero blanking enable, level-sampled every cycle.
- A  out  4  current digit BCD to the decoder (A[3]..A[0] map to decoder A3..A0); registered.
- EN  out  1  decoder enable; 0 forces the decoder's blank pattern; registered.
- SEL_N  out  4  active-low digit select, one-hot-low; SEL_N[i]=0 lights digit i; registered.
- FRAME  out  1  one-cycle pulse at each frame boundary (digit 3 to digit 0); registered.

## Operation
- State: slot counter CNT (0..PRESCALE-1), digit index IDX (0..3), display register DISP[15:0], shadow SHD[15:0], flag PEND.
- CNT increments every cycle. At CNT=PRESCALE-1 a tick occurs: CNT wraps to 0 and IDX advances 0→1→2→3→0.
- A tick with IDX=3 is a frame boundary. If PEND=1, DISP takes SHD and PEND clears. FRAME pulses on the boundary.
- LOAD=1: SHD takes D and PEND is set. A LOAD while PEND=1 overwrites SHD (last write wins).
- LOAD on the boundary cycle: the boundary copies the pre-LOAD SHD if PEND was set. The new D goes into SHD, and PEND ends the cycle at 1.
- Nibble values above 9 pass through unchanged on A; the decoder blanks them.
- Leading-zero blanking applies when LZB=1. Digit i (i=3,2,1) is blanked when DISP nibble i and every higher nibble are 0. Digit 0 is never blanked.
- Output values for the selected digit IDX:
  - Blank window (CNT<BLANK_CYC): SEL_N=4'b1111, EN=0, A=DISP nibble IDX.
  - Leading-zero-blanked digit: SEL_N=4'b1111, EN=0 for the whole slot.
  - Otherwise: SEL_N has bit IDX low and all other bits high, EN=1, A=DISP nibble IDX.

## Timing
- Reset values (RST_N=0 at a rising edge): CNT=0, IDX=0, DISP=0, SHD=0, PEND=0, A=4'h0, EN=0, SEL_N=4'b1111, FRAME=0.
- Reset applied mid-slot or mid-frame discards the display, shadow and pending state immediately.
- Outputs are registered. They reflect the new CNT/IDX state at the same edge on which CNT/IDX update, with no extra pipeline stage.
- Slot length is exactly PRESCALE cycles. Frame length is 4×PRESCALE cycles.
- LOAD-to-display latency: the value appears in the first slot of the next frame, at most 4×PRESCALE+1 cycles after LOAD.
- After reset, the first displayed slot is digit 0. The first frame boundary occurs 4×PRESCALE cycles after reset deasserts.

## Structure
- Package display_pkg holds:
  - DIGITS=4.
  - SEL_OFF=4'b1111.
  - A function mapping a 2-bit index to a one-hot-low select.
  - A function returning the leading-zero blank mask from a 16-bit BCD value.
- One sub-module, scan_prescaler. It contains CNT and the tick output, is parameterised by PRESCALE, and exposes CNT for the blank-window compare.
- The top level holds IDX, DISP/SHD/PEND, blanking logic and the output registers.

## Test plan
All scenarios use PRESCALE=8 and BLANK_CYC=2.
- Reset: hold RST_N=0 for 3 cycles, then release → SEL_N=1111, EN=0, A=0, FRAME=0 during reset. Digit 0 is selected (SEL_N=1110) from CNT=2.
- Scan: LOAD D=16'h1234 with LZB=0 → next frame shows digits with A=4,3,2,1 and SEL_N=1110,1101,1011,0111. Each slot is 8 cycles, the first 2 with SEL_N=1111. FRAME pulses every 32 cycles.
- Leading-zero blanking: D=16'h0050, LZB=1 → digits 3 and 2 have SEL_N=1111 and EN=0 for their full slots. Digit 1 shows A=5 and digit 0 shows A=0. With D=16'h0000, only digit 0 lights, showing A=0.
- Tear-free update: LOAD 16'h1111 mid-frame, then LOAD 16'h9999 before the boundary → no 1111 frame ever appears. The next frame shows 9999 and PEND clears.
- LOAD on the boundary cycle: SHD pending 16'h2222, LOAD 16'h7777 coincident with the tick at IDX=3 → this frame shows 2222 and the following frame shows 7777.
- Mid-frame reset: pulse RST_N low at IDX=2, CNT=5 → the next edge gives reset values. DISP=0, so digit 0 subsequently shows A=0.
